// File: rtl/load_store_unit_pkg.sv
// ----------------------------------------------------------------------------
// load_store_unit_pkg
// Shared definitions for the load/store unit: RV32 width codes, the four-state
// access sequencer encoding and small decode helpers used by both the request
// decoder and the load writeback path.
// No ports (package).
// ----------------------------------------------------------------------------
package load_store_unit_pkg;

    localparam int DATA_W = 32;

    // RV32 funct3 width codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    // Codes with no RV32 meaning; stores only exist for B/H/W.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && (f3 > F3_W));
    endfunction

    // Address bits that must be zero for a naturally aligned access.
    function automatic logic [1:0] low_mask(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 2'b00;
            2'b01:   return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// ----------------------------------------------------------------------------
// lsu_load_align
// Purely combinational load data alignment: shifts the read word down to the
// addressed byte lane and sign- or zero-extends according to funct3.
// Ports:
//   rdata   in  32  word returned by memory
//   addr_lo in  2   byte offset within the word
//   funct3  in  3   RV32 load width code
//   result  out 32  aligned, extended load value
// ----------------------------------------------------------------------------
module lsu_load_align
    import load_store_unit_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        addr_lo,
    input  logic [2:0]        funct3,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0]        shifted;
    logic signed [7:0]        byte_s;
    logic signed [15:0]       half_s;
    logic signed [DATA_W-1:0] byte_ext;
    logic signed [DATA_W-1:0] half_ext;

    always_comb begin
        shifted  = rdata >> {addr_lo, 3'b000};
        byte_s   = shifted[7:0];
        half_s   = shifted[15:0];
        byte_ext = 32'(byte_s);
        half_ext = 32'(half_s);
        case (funct3)
            F3_B:    result = byte_ext;
            F3_H:    result = half_ext;
            F3_BU:   result = {24'b0, shifted[7:0]};
            F3_HU:   result = {16'b0, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
// Sequences one data-memory access per request (IDLE -> REQ -> WAIT -> DONE)
// between the core address path and a valid/ready memory bus. Stores get
// lane-replicated data and byte strobes; loads are aligned and extended.
// Illegal width codes and WAIT-state timeouts complete with an error.
//
// Build option: define LSU_MISALIGN_TRAP_EN to complete misaligned requests
// with an error and no bus traffic; when undefined, the address bits below the
// access width are cleared and the access proceeds normally.
//
// Parameter: TIMEOUT (>=2) WAIT cycles allowed before an access is abandoned.
// Ports:
//   lsu_clk, lsu_rst_n                 clock, synchronous active-low reset
//   lsu_req_valid/ready/we/funct3/addr/wdata   core request
//   mem_req_valid/ready, mem_addr/we/wstrb/wdata   bus request
//   mem_rsp_valid, mem_rdata           bus response / store acknowledge
//   lsu_rsp_valid/rdata/err            one-cycle completion to writeback
// ----------------------------------------------------------------------------
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic              lsu_clk,
    input  logic              lsu_rst_n,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic              lsu_req_we,
    input  logic [2:0]        lsu_req_funct3,
    input  logic [DATA_W-1:0] lsu_req_addr,
    input  logic [DATA_W-1:0] lsu_req_wdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [DATA_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_wstrb,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lsu_rsp_valid,
    output logic [DATA_W-1:0] lsu_rsp_rdata,
    output logic              lsu_rsp_err
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e        state, state_next;
    logic              we_r;
    logic [2:0]        f3_r;
    logic [1:0]        addr_lo_r;
    logic [CNT_W-1:0]  cnt;

    logic              req_trap;
    logic [DATA_W-1:0] req_addr_eff;
    logic [3:0]        store_strb;
    logic [DATA_W-1:0] store_wdata;
    logic [DATA_W-1:0] load_data;

    // Request decode: trap condition, effective address and store lanes.
    always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
        req_trap     = f3_illegal(lsu_req_we, lsu_req_funct3)
                     || (|(lsu_req_addr[1:0] & low_mask(lsu_req_funct3)));
        req_addr_eff = lsu_req_addr;
`else
        req_trap     = f3_illegal(lsu_req_we, lsu_req_funct3);
        req_addr_eff = {lsu_req_addr[31:2], lsu_req_addr[1:0] & ~low_mask(lsu_req_funct3)};
`endif
        store_strb  = 4'b0000;
        store_wdata = '0;
        if (lsu_req_we) begin
            case (lsu_req_funct3)
                F3_B: begin
                    store_strb  = 4'b0001 << req_addr_eff[1:0];
                    store_wdata = {4{lsu_req_wdata[7:0]}};
                end
                F3_H: begin
                    store_strb  = 4'b0011 << {req_addr_eff[1], 1'b0};
                    store_wdata = {2{lsu_req_wdata[15:0]}};
                end
                default: begin
                    store_strb  = 4'b1111;
                    store_wdata = lsu_req_wdata;
                end
            endcase
        end
    end

    lsu_load_align u_align (
        .rdata   (mem_rdata),
        .addr_lo (addr_lo_r),
        .funct3  (f3_r),
        .result  (load_data)
    );

    // State register
    always_ff @(posedge lsu_clk) begin
        if (!lsu_rst_n) state <= ST_IDLE;
        else            state <= state_next;
    end

    // Next-state logic; the response input only matters in WAIT.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (lsu_req_valid) state_next = req_trap ? ST_DONE : ST_REQ;
            ST_REQ:  if (mem_req_ready) state_next = ST_WAIT;
            ST_WAIT: if (mem_rsp_valid || (cnt == CNT_LAST)) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Control outputs decoded from state
    always_comb begin
        lsu_req_ready = (state == ST_IDLE);
        mem_req_valid = (state == ST_REQ);
        lsu_rsp_valid = (state == ST_DONE);
    end

    // Request capture, bus fields, timeout counter and response data.
    always_ff @(posedge lsu_clk) begin
        if (!lsu_rst_n) begin
            we_r          <= 1'b0;
            f3_r          <= '0;
            addr_lo_r     <= '0;
            cnt           <= '0;
            mem_addr      <= '0;
            mem_we        <= 1'b0;
            mem_wstrb     <= '0;
            mem_wdata     <= '0;
            lsu_rsp_rdata <= '0;
            lsu_rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (lsu_req_valid) begin
                        we_r          <= lsu_req_we;
                        f3_r          <= lsu_req_funct3;
                        addr_lo_r     <= req_addr_eff[1:0];
                        lsu_rsp_rdata <= '0;
                        lsu_rsp_err   <= req_trap;
                        // Bus fields are only updated for accesses that go out,
                        // so they stay stable for the whole REQ phase.
                        if (!req_trap) begin
                            mem_addr  <= {req_addr_eff[31:2], 2'b00};
                            mem_we    <= lsu_req_we;
                            mem_wstrb <= store_strb;
                            mem_wdata <= store_wdata;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) cnt <= '0;
                end
                ST_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (mem_rsp_valid) begin
                        lsu_rsp_rdata <= we_r ? '0 : load_data;
                        lsu_rsp_err   <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        lsu_rsp_rdata <= '0;
                        lsu_rsp_err   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    lsu_rsp_rdata <= '0;
                    lsu_rsp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
module tb_load_store_unit;

    localparam int TIMEOUT = 8;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lsu_req_valid = 1'b0;
    logic        lsu_req_ready;
    logic        lsu_req_we = 1'b0;
    logic [2:0]  lsu_req_funct3 = '0;
    logic [31:0] lsu_req_addr = '0;
    logic [31:0] lsu_req_wdata = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        lsu_rsp_valid;
    logic [31:0] lsu_rsp_rdata;
    logic        lsu_rsp_err;

    load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
        .lsu_clk        (clk),
        .lsu_rst_n      (rst_n),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_req_we     (lsu_req_we),
        .lsu_req_funct3 (lsu_req_funct3),
        .lsu_req_addr   (lsu_req_addr),
        .lsu_req_wdata  (lsu_req_wdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_wstrb      (mem_wstrb),
        .mem_wdata      (mem_wdata),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rdata      (mem_rdata),
        .lsu_rsp_valid  (lsu_rsp_valid),
        .lsu_rsp_rdata  (lsu_rsp_rdata),
        .lsu_rsp_err    (lsu_rsp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Expectations of the current transaction
    bit          busy = 0, expect_bus = 0, quiet = 1, rsp_seen = 0, last_rsp = 0;
    int          rsp_cyc = 0;
    logic [31:0] exp_maddr, exp_mwdata, exp_rdata;
    logic [3:0]  exp_strb;
    logic        exp_we, exp_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int m_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit m_err(input bit we, input logic [2:0] f3, input logic [31:0] addr);
        bit illegal = (f3 == 3) || (f3 == 6) || (f3 == 7) || (we && f3 > 2);
        return illegal || (TRAP && (addr % m_size(f3)) != 0);
    endfunction

    function automatic logic [31:0] m_eff(input logic [2:0] f3, input logic [31:0] addr);
        return addr - (addr % m_size(f3));
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] word);
        int size = m_size(f3);
        int off  = m_eff(f3, addr) % 4;
        longint v, span;
        if (size == 4) return word;
        v    = longint'(word) >> (8 * off);
        span = longint'(1) << (8 * size);
        v    = v % span;
        if (!f3[2] && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] addr);
        logic [3:0] s = '0;
        int size = m_size(f3);
        int off  = m_eff(f3, addr) % 4;
        for (int i = 0; i < 4; i++) if (i >= off && i < off + size) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wdata);
        logic [31:0] r;
        int size = m_size(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wdata[8*(i % size) +: 8];
        return r;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!quiet) check("req_ready", {31'b0, lsu_req_ready}, {31'b0, !busy});
        check("unexpected_mem_req", {31'b0, mem_req_valid & ~expect_bus}, 32'd0);
        if (mem_req_valid && expect_bus) begin
            check("mem_addr",  mem_addr, exp_maddr);
            check("mem_we",    {31'b0, mem_we}, {31'b0, exp_we});
            check("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, exp_strb});
            check("mem_wdata", mem_wdata, exp_mwdata);
        end
        check("unexpected_rsp", {31'b0, lsu_rsp_valid & ~busy}, 32'd0);
        check("rsp_pulse_width", {31'b0, lsu_rsp_valid & last_rsp}, 32'd0);
        if (lsu_rsp_valid && busy) begin
            check("rsp_rdata", lsu_rsp_rdata, exp_rdata);
            check("rsp_err", {31'b0, lsu_rsp_err}, {31'b0, exp_err});
            rsp_cyc    = cyc;
            rsp_seen   = 1;
            busy       = 0;
            expect_bus = 0;
        end
        last_rsp = lsu_rsp_valid;
    end

    // Present one request and let it be accepted; returns the request cycle.
    task automatic present(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output int req_c);
        int t = 0;
        while (!lsu_req_ready && t < 50) begin @(posedge clk); #1; t++; end
        lsu_req_we     = we;
        lsu_req_funct3 = f3;
        lsu_req_addr   = addr;
        lsu_req_wdata  = wdata;
        lsu_req_valid  = 1'b1;
        req_c          = cyc;
        rsp_seen       = 0;
        @(posedge clk); #1;
        lsu_req_valid  = 1'b0;
        busy           = 1;
    endtask

    // Full access: rsp_lag < 0 means memory never answers (timeout expected).
    task automatic access(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int ready_lag, input int rsp_lag,
                          input logic [31:0] word, input string name);
        int t, req_c, lat, exp_lat;
        bit err = m_err(we, f3, addr);
        exp_maddr  = m_eff(f3, addr) & ~32'd3;
        exp_we     = we;
        exp_strb   = we ? m_strb(f3, addr) : 4'b0000;
        exp_mwdata = we ? m_wdata(f3, wdata) : 32'd0;
        exp_err    = err || (rsp_lag < 0);
        exp_rdata  = (exp_err || we) ? 32'd0 : m_load(f3, addr, word);
        exp_lat    = err ? 1 : (rsp_lag < 0) ? 2 + ready_lag + TIMEOUT : 3 + ready_lag + rsp_lag;
        expect_bus = !err;
        present(we, f3, addr, wdata, req_c);
        if (!err) begin
            mem_req_ready = (ready_lag == 0);
            repeat (ready_lag) begin @(posedge clk); #1; end
            mem_req_ready = 1'b1;
            @(posedge clk); #1;
            mem_req_ready = 1'b0;
            if (rsp_lag >= 0) begin
                repeat (rsp_lag) begin @(posedge clk); #1; end
                mem_rsp_valid = 1'b1;
                mem_rdata     = word;
                @(posedge clk); #1;
                mem_rsp_valid = 1'b0;
                mem_rdata     = 32'd0;
            end
        end
        t = 0;
        while (!rsp_seen && t < TIMEOUT + 40) begin @(posedge clk); #1; t++; end
        lat = rsp_seen ? rsp_cyc - req_c : -1;
        check({name, "_latency"}, lat, exp_lat);
        if (rsp_lag < 0) begin
            // late response after the timeout must be discarded
            mem_rsp_valid = 1'b1;
            mem_rdata     = 32'h5A5A5A5A;
            repeat (2) begin @(posedge clk); #1; end
            mem_rsp_valid = 1'b0;
            mem_rdata     = 32'd0;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int req_c;
        repeat (2) @(posedge clk);
        #1;
        // reset state
        check("rst_ready",     {31'b0, lsu_req_ready}, 32'd1);
        check("rst_mem_valid", {31'b0, mem_req_valid}, 32'd0);
        check("rst_mem_addr",  mem_addr, 32'd0);
        check("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_rsp_valid", {31'b0, lsu_rsp_valid}, 32'd0);
        check("rst_rsp_rdata", lsu_rsp_rdata, 32'd0);
        check("rst_rsp_err",   {31'b0, lsu_rsp_err}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        quiet = 0;

        // model pins from hand-computed values
        check("pin_lw",       m_load(3'b010, 32'h100, 32'hDEADBEEF), 32'hDEADBEEF);
        check("pin_lb",       m_load(3'b000, 32'h103, 32'h80FF0000), 32'hFFFFFF80);
        check("pin_lbu",      m_load(3'b100, 32'h103, 32'h80FF0000), 32'h00000080);
        check("pin_lh",       m_load(3'b001, 32'h102, 32'h80FF0000), 32'hFFFF80FF);
        check("pin_sh_addr",  m_eff(3'b001, 32'h0A) & ~32'd3, 32'h08);
        check("pin_sh_strb",  {28'b0, m_strb(3'b001, 32'h0A)}, 32'hC);
        check("pin_sh_wdata", m_wdata(3'b001, 32'h1234ABCD), 32'hABCDABCD);
        check("pin_sb_wdata", m_wdata(3'b000, 32'h00000077), 32'h77777777);
        check("pin_lw102_err", {31'b0, m_err(1'b0, 3'b010, 32'h102)}, {31'b0, TRAP});

        // loads
        access(0, 3'b010, 32'h100, 0, 0, 0, 32'hDEADBEEF, "lw");
        access(0, 3'b000, 32'h103, 0, 0, 0, 32'h80FF0000, "lb");
        access(0, 3'b100, 32'h103, 0, 0, 0, 32'h80FF0000, "lbu");
        access(0, 3'b001, 32'h102, 0, 1, 2, 32'h80FF0000, "lh");
        access(0, 3'b101, 32'h100, 0, 0, 1, 32'h80FF7F00, "lhu");
        // stores (ack carries junk rdata which must not leak out)
        access(1, 3'b001, 32'h0A, 32'h1234ABCD, 0, 1, 32'hFFFFFFFF, "sh");
        access(1, 3'b000, 32'h05, 32'h00000077, 2, 0, 32'hFFFFFFFF, "sb");
        access(1, 3'b010, 32'h20, 32'hCAFEF00D, 0, 0, 32'hFFFFFFFF, "sw");
        // illegal codes
        access(0, 3'b011, 32'h40, 0, 0, 0, 32'h12345678, "illegal_ld");
        access(1, 3'b100, 32'h40, 32'h11, 0, 0, 32'h12345678, "illegal_st");
        // misaligned
        access(0, 3'b010, 32'h102, 0, 0, 0, 32'hCAFEF00D, "lw_misaligned");
        access(1, 3'b001, 32'h33, 32'hBEEF, 0, 0, 32'h0, "sh_misaligned");
        // stalled handshake then no response
        access(0, 3'b010, 32'h200, 0, 5, -1, 32'h0, "timeout");

        // reset while in WAIT
        exp_maddr = 32'h40; exp_we = 0; exp_strb = 4'b0000; exp_mwdata = 32'd0;
        expect_bus = 1;
        present(0, 3'b010, 32'h40, 0, req_c);
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        quiet = 1; busy = 0; expect_bus = 0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_ready",     {31'b0, lsu_req_ready}, 32'd1);
        check("midrst_mem_valid", {31'b0, mem_req_valid}, 32'd0);
        check("midrst_mem_addr",  mem_addr, 32'd0);
        check("midrst_rsp_valid", {31'b0, lsu_rsp_valid}, 32'd0);
        check("midrst_rsp_err",   {31'b0, lsu_rsp_err}, 32'd0);
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h77777777;
        repeat (2) begin @(posedge clk); #1; end
        mem_rsp_valid = 1'b0;
        mem_rdata     = 32'd0;
        quiet = 0;

        // normal operation after reset
        access(0, 3'b000, 32'h101, 0, 0, 0, 32'h0000A500, "lb_after_rst");

        repeat (2) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
